// File: rtl/keygen_arbiter.sv
// Two-requester round-robin front end for a shared key generator.
// Latency: grant (req_ready) to rsp_valid is 3 cycles plus generator cycles. Backpressure: req_valid is held until req_ready.
// Optional WAIT timeout is enabled with KEYGEN_TIMEOUT_EN.
`timescale 1ns/1ps
module keygen_arbiter #(
    parameter int DATA_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    input  logic [3:0]              req_instr,
    input  logic [2*DATA_WIDTH-1:0] req_key,
    input  logic [2*DATA_WIDTH-1:0] req_k,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_key,
    output logic                    rsp_err,
    output logic                    gen_rst_n,
    output logic [1:0]              gen_instruction,
    output logic [DATA_WIDTH-1:0]   gen_key_in,
    output logic [DATA_WIDTH-1:0]   gen_k,
    input  logic                    gen_done,
    input  logic [DATA_WIDTH-1:0]   gen_key_out
);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [1:0]            instr;
        logic [DATA_WIDTH-1:0] key;
        logic [DATA_WIDTH-1:0] k;
    } job_t;

    state_t                r_state;
    state_t                w_state_nxt;
    job_t                  r_job;
    job_t                  w_req_job;
    logic                  r_gnt;
    logic                  r_last;
    logic                  w_gnt;
    logic                  w_timeout;
    logic [1:0]            r_req_ready;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_key;
    logic                  r_rsp_err;
    logic                  r_gen_rst_n;
    job_t                  r_gen;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_gnt = 1'b0;
        if (req_valid == 2'b11) begin
            w_gnt = ~r_last;
        end else begin
            w_gnt = req_valid[1];
        end
    end

    always_comb begin
        w_req_job.instr = w_gnt ? req_instr[3:2] : req_instr[1:0];
        w_req_job.key   = w_gnt ? req_key[2*DATA_WIDTH-1:DATA_WIDTH] : req_key[DATA_WIDTH-1:0];
        w_req_job.k     = w_gnt ? req_k[2*DATA_WIDTH-1:DATA_WIDTH]   : req_k[DATA_WIDTH-1:0];
    end

`ifdef KEYGEN_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // A gen_done arriving on the last allowed cycle still counts as success.
    assign w_timeout = (r_state == WAIT) && !gen_done &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req_valid) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (gen_done || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is valid for the whole cycle of its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_job       <= '0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_req_ready <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_key   <= '0;
            r_rsp_err   <= 1'b0;
            r_gen_rst_n <= 1'b0;
            r_gen       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_gen_rst_n <= (w_state_nxt != CLEAR);

            if (r_state == IDLE && |req_valid) begin
                r_req_ready <= w_gnt ? 2'b10 : 2'b01;
                r_gnt       <= w_gnt;
                r_last      <= w_gnt;
                r_job       <= w_req_job;
            end

            if (w_state_nxt == ISSUE || w_state_nxt == WAIT) begin
                r_gen <= r_job;
            end else begin
                r_gen <= '0;
            end

            if (r_state == WAIT && w_state_nxt == RESP) begin
                r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                r_rsp_key   <= w_timeout ? '0 : gen_key_out;
                r_rsp_err   <= w_timeout;
            end
        end
    end

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_key         = r_rsp_key;
    assign rsp_err         = r_rsp_err;
    assign gen_rst_n       = r_gen_rst_n;
    assign gen_instruction = r_gen.instr;
    assign gen_key_in      = r_gen.key;
    assign gen_k           = r_gen.k;

endmodule

// File: tb/tb_keygen_arbiter.sv
// Directed bench for keygen_arbiter: reset, single job, contention, key routing, mid-job reset, stray gen_done.
`timescale 1ns/1ps
module tb_keygen_arbiter;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [3:0]    req_instr;
    logic [2*DW-1:0] req_key;
    logic [2*DW-1:0] req_k;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_key;
    logic          rsp_err;
    logic          gen_rst_n;
    logic [1:0]    gen_instruction;
    logic [DW-1:0] gen_key_in;
    logic [DW-1:0] gen_k;
    logic          gen_done;
    logic [DW-1:0] gen_key_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keygen_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_instr(req_instr), .req_key(req_key), .req_k(req_k),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_key(rsp_key), .rsp_err(rsp_err),
        .gen_rst_n(gen_rst_n), .gen_instruction(gen_instruction),
        .gen_key_in(gen_key_in), .gen_k(gen_k),
        .gen_done(gen_done), .gen_key_out(gen_key_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string ctx);
        check({ctx, "_req_ready"}, {30'd0, req_ready}, 32'h0);
        check({ctx, "_rsp_valid"}, {30'd0, rsp_valid}, 32'h0);
        check({ctx, "_rsp_key"}, {20'd0, rsp_key}, 32'h0);
        check({ctx, "_rsp_err"}, {31'd0, rsp_err}, 32'h0);
        check({ctx, "_gen_rst_n"}, {31'd0, gen_rst_n}, 32'h0);
        check({ctx, "_gen_instr"}, {30'd0, gen_instruction}, 32'h0);
        check({ctx, "_gen_key_in"}, {20'd0, gen_key_in}, 32'h0);
        check({ctx, "_gen_k"}, {20'd0, gen_k}, 32'h0);
    endtask

    // Entered in IDLE with req_valid already driven; leaves in IDLE right after RESP.
    task automatic run_job(input int g, input logic [1:0] instr, input logic [DW-1:0] key,
                           input logic [DW-1:0] k, input logic [DW-1:0] res, input int nwait);
        logic [1:0] oh;
        oh = (g == 1) ? 2'b10 : 2'b01;
        tick();
        check("grant_ready", {30'd0, req_ready}, {30'd0, oh});
        check("clear_gen_rst_n", {31'd0, gen_rst_n}, 32'h0);
        check("clear_gen_instr", {30'd0, gen_instruction}, 32'h0);
        tick();
        check("issue_gen_rst_n", {31'd0, gen_rst_n}, 32'h1);
        check("issue_ready_low", {30'd0, req_ready}, 32'h0);
        check("issue_instr", {30'd0, gen_instruction}, {30'd0, instr});
        check("issue_key", {20'd0, gen_key_in}, {20'd0, key});
        check("issue_k", {20'd0, gen_k}, {20'd0, k});
        for (int i = 0; i < nwait; i++) begin
            tick();
            check("wait_key", {20'd0, gen_key_in}, {20'd0, key});
            check("wait_k", {20'd0, gen_k}, {20'd0, k});
            check("wait_no_rsp", {30'd0, rsp_valid}, 32'h0);
        end
        gen_done    = 1'b1;
        gen_key_out = res;
        tick();
        gen_done    = 1'b0;
        gen_key_out = '0;
        check("resp_valid", {30'd0, rsp_valid}, {30'd0, oh});
        check("resp_key", {20'd0, rsp_key}, {20'd0, res});
        check("resp_err", {31'd0, rsp_err}, 32'h0);
        check("resp_gen_key_zero", {20'd0, gen_key_in}, 32'h0);
        tick();
        check("post_rsp_valid_low", {30'd0, rsp_valid}, 32'h0);
        check("post_rsp_key_held", {20'd0, rsp_key}, {20'd0, res});
        check("post_ready_low", {30'd0, req_ready}, 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        req_instr   = 4'b0000;
        req_key     = '0;
        req_k       = '0;
        gen_done    = 1'b0;
        gen_key_out = '0;
        repeat (3) tick();
        check_reset_outputs("reset");

        rst_n = 1'b1;
        tick();
        check("release_gen_rst_n", {31'd0, gen_rst_n}, 32'h1);

        // Stray gen_done in IDLE
        gen_done    = 1'b1;
        gen_key_out = 12'hABC;
        tick();
        tick();
        gen_done    = 1'b0;
        check("stray_no_rsp", {30'd0, rsp_valid}, 32'h0);
        check("stray_still_idle", {31'd0, gen_rst_n}, 32'h1);
        check("stray_rsp_key", {20'd0, rsp_key}, 32'h0);

        // Single job from requester 0
        req_valid = 2'b01;
        req_instr = 4'b0001;
        req_key   = {12'h000, 12'h5A3};
        req_k     = {12'h000, 12'h010};
        run_job(0, 2'b01, 12'h5A3, 12'h010, 12'hC3F, 19);
        req_valid = 2'b00;

        // Contention with key routing; requester 0 was served last
        req_valid = 2'b11;
        req_instr = 4'b1110;
        req_key   = {12'h7FF, 12'h111};
        req_k     = {12'h123, 12'h222};
        run_job(1, 2'b11, 12'h7FF, 12'h123, 12'h456, 3);
        run_job(0, 2'b10, 12'h111, 12'h222, 12'h789, 2);
        run_job(1, 2'b11, 12'h7FF, 12'h123, 12'h0A5, 4);
        run_job(0, 2'b10, 12'h111, 12'h222, 12'hF00, 1);

        // Mid-job reset: requester 1 holds priority, then reset restores requester 0
        tick();
        check("pre_reset_grant", {30'd0, req_ready}, 32'h2);
        repeat (3) tick();
        rst_n    = 1'b0;
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check_reset_outputs("midjob");
        rst_n = 1'b1;
        run_job(0, 2'b10, 12'h111, 12'h222, 12'h321, 2);
        run_job(1, 2'b11, 12'h7FF, 12'h123, 12'h654, 2);
        req_valid = 2'b00;
        tick();
        check("idle_no_grant", {30'd0, req_ready}, 32'h0);

`ifdef KEYGEN_TIMEOUT_EN
        req_valid   = 2'b01;
        gen_key_out = 12'hABC;
        tick();
        check("to_grant", {30'd0, req_ready}, 32'h1);
        req_valid = 2'b00;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_wait_no_rsp", {30'd0, rsp_valid}, 32'h0);
        end
        tick();
        check("to_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        check("to_rsp_key", {20'd0, rsp_key}, 32'h0);
        check("to_rsp_err", {31'd0, rsp_err}, 32'h1);
        tick();
        check("to_rsp_err_held", {31'd0, rsp_err}, 32'h1);
        check("to_rsp_valid_low", {30'd0, rsp_valid}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
